// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// master: the controller (takes instruction fields and flags, drives strobes and selects).
// slave : the datapath side (drives instruction fields and flags, takes strobes and selects).
//   op, funct3, funct7b5 : instruction fields from the IR
//   zero                 : ALU zero flag
//   mem_ready            : memory access completes this cycle
//   mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite : strobes and address select
//   resultsrc, alusrca, alusrcb, alucontrol, immsrc       : datapath mux and ALU controls
//   illegal, state                                        : trap flag and debug state
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] immsrc;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, alucontrol, immsrc, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite,
           resultsrc, alusrca, alusrcb, alucontrol, immsrc, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main controller for the multicycle RV32I datapath (lw, sw, R-type, I-type ALU, beq, jal).
// Sequences fetch/decode/execute/memory/writeback, stalls memory states on mem_ready and
// traps on any unsupported opcode. Only the state is registered; all outputs are decoded
// combinationally from state and the bus inputs.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; forces FETCH and masks all strobes while high
//   bus   : multicycle_ctrl_if.master, instruction fields/flags in, strobes/selects out
module multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StAluWb    = 4'd7;
  localparam logic [3:0] StExecI    = 4'd8;
  localparam logic [3:0] StJal      = 4'd9;
  localparam logic [3:0] StBeq      = 4'd10;
  localparam logic [3:0] StTrap     = 4'd11;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  logic [3:0] state_q, state_d;
  logic [3:0] cur;
  logic       ready;
  logic [2:0] alu_funct;

  assign ready = USE_MEM_READY ? bus.mem_ready : 1'b1;
  // While reset is high the decode behaves as FETCH so the muxes show fetch values.
  assign cur   = reset ? StFetch : state_q;
  assign bus.state = state_q;

  // ALU operation for EXECR/EXECI; op[5] separates R-type (sub allowed) from I-type.
  always_comb begin
    alu_funct = AluAdd;
    case (bus.funct3)
      3'b000:  alu_funct = (bus.funct7b5 & bus.op[5]) ? AluSub : AluAdd;
      3'b010:  alu_funct = AluSlt;
      3'b110:  alu_funct = AluOr;
      3'b111:  alu_funct = AluAnd;
      default: alu_funct = AluAdd;
    endcase
  end

  always_comb begin
    bus.immsrc = 2'b00;
    case (bus.op)
      OpStore: bus.immsrc = 2'b01;
      OpBeq:   bus.immsrc = 2'b10;
      OpJal:   bus.immsrc = 2'b11;
      default: bus.immsrc = 2'b00;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.pcwrite    = 1'b0;
    bus.adrsrc     = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regwrite   = 1'b0;
    bus.resultsrc  = 2'b00;
    bus.alusrca    = 2'b00;
    bus.alusrcb    = 2'b00;
    bus.alucontrol = AluAdd;
    bus.illegal    = 1'b0;

    case (cur)
      StFetch: begin
        bus.mem_req   = 1'b1;
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        bus.irwrite   = ready;
        bus.pcwrite   = ready;
        if (ready) state_d = StDecode;
      end
      StDecode: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        state_d     = bus.op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.adrsrc  = 1'b1;
        if (ready) state_d = StMemWb;
      end
      StMemWb: begin
        bus.resultsrc = 2'b01;
        bus.regwrite  = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        bus.mem_req  = 1'b1;
        bus.adrsrc   = 1'b1;
        bus.memwrite = 1'b1;
        if (ready) state_d = StFetch;
      end
      StExecR: begin
        bus.alusrca    = 2'b10;
        bus.alucontrol = alu_funct;
        state_d        = StAluWb;
      end
      StExecI: begin
        bus.alusrca    = 2'b10;
        bus.alusrcb    = 2'b01;
        bus.alucontrol = alu_funct;
        state_d        = StAluWb;
      end
      StAluWb: begin
        bus.regwrite = 1'b1;
        state_d      = StFetch;
      end
      StJal: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        bus.pcwrite = 1'b1;
        state_d     = StAluWb;
      end
      StBeq: begin
        bus.alusrca    = 2'b10;
        bus.alucontrol = AluSub;
        bus.pcwrite    = bus.zero;
        state_d        = StFetch;
      end
      StTrap: begin
        bus.illegal = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    if (reset) begin
      bus.mem_req  = 1'b0;
      bus.pcwrite  = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.memwrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcwrite, irwrite, regwrite, memwrite, mem_req}
  logic [4:0] strobes;
  assign strobes = {bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite, bus.mem_req};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
  endtask

  // Leaves the controller in FETCH, reset low.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (strobes !== 5'b0 || bus.illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_strobes cyc%0d: got strobes=%b illegal=%b, want 00000 0", i, strobes,
                 bus.illegal);
      end
      tick();
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 4'd0 || strobes !== 5'b11001) begin
      miscompares++;
      $display("FAIL reset_release: got state=%0d strobes=%b, want 0 11001", bus.state, strobes);
    end
    tick();
    vectors++;
    if (bus.state !== 4'd1) begin
      miscompares++;
      $display("FAIL reset_to_decode: got state=%0d, want 1", bus.state);
    end
    // FETCH stalls without mem_ready: request stays up, no IR/PC write.
    do_reset();
    bus.mem_ready = 1'b0;
    #1;
    vectors++;
    if (strobes !== 5'b00001) begin
      miscompares++;
      $display("FAIL fetch_wait: got strobes=%b, want 00001", strobes);
    end
    tick();
    vectors++;
    if (bus.state !== 4'd0) begin
      miscompares++;
      $display("FAIL fetch_hold: got state=%0d, want 0", bus.state);
    end
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    set_instr(7'b0000011, 3'b010, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      vectors++;
      if (bus.state !== exp_st[i] || bus.regwrite !== (i == 6) || bus.immsrc !== 2'b00) begin
        miscompares++;
        $display("FAIL lw step%0d: got state=%0d regwrite=%b immsrc=%b, want %0d %b 00", i,
                 bus.state, bus.regwrite, bus.immsrc, exp_st[i], (i == 6));
      end
      if (i == 6) begin
        vectors++;
        if (bus.resultsrc !== 2'b01) begin
          miscompares++;
          $display("FAIL lw_resultsrc: got %b, want 01", bus.resultsrc);
        end
      end
      if (i == 3) begin
        vectors++;
        if (bus.adrsrc !== 1'b1 || bus.mem_req !== 1'b1) begin
          miscompares++;
          $display("FAIL lw_memread: got adrsrc=%b mem_req=%b, want 1 1", bus.adrsrc,
                   bus.mem_req);
        end
      end
      if (i < 7) tick();
    end
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    int         writes = 0;
    set_instr(7'b0100011, 3'b010, 1'b0);
    bus.mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.memwrite === 1'b1) writes++;
      vectors++;
      if (bus.state !== exp_st[i] || bus.immsrc !== 2'b01) begin
        miscompares++;
        $display("FAIL sw step%0d: got state=%0d immsrc=%b, want %0d 01", i, bus.state,
                 bus.immsrc, exp_st[i]);
      end
      if (i == 3) begin
        vectors++;
        if (bus.adrsrc !== 1'b1 || bus.memwrite !== 1'b1) begin
          miscompares++;
          $display("FAIL sw_memwrite: got adrsrc=%b memwrite=%b, want 1 1", bus.adrsrc,
                   bus.memwrite);
        end
      end
      if (i < 4) tick();
    end
    vectors++;
    if (writes !== 1) begin
      miscompares++;
      $display("FAIL sw_write_count: got %0d, want 1", writes);
    end
  endtask

  task automatic test_alu();
    // {op, funct3, funct7b5, expected state, expected alucontrol, expected alusrcb}
    logic [6:0] ops [7] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                            7'b0010011, 7'b0010011};
    logic [2:0] f3s [7] = '{3'b000, 3'b000, 3'b110, 3'b111, 3'b010, 3'b000, 3'b100};
    logic       f7s [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] alu [7] = '{3'b001, 3'b000, 3'b011, 3'b010, 3'b101, 3'b000, 3'b000};
    logic [3:0] st  [7] = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd8, 4'd8};
    logic [1:0] srb [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_instr(ops[i], f3s[i], f7s[i]);
      do_reset();
      tick();
      tick();
      vectors++;
      if (bus.state !== st[i] || bus.alucontrol !== alu[i] || bus.alusrca !== 2'b10 ||
          bus.alusrcb !== srb[i] || bus.regwrite !== 1'b0) begin
        miscompares++;
        $display("FAIL alu vec%0d: got state=%0d alu=%b a=%b b=%b rw=%b, want %0d %b 10 %b 0",
                 i, bus.state, bus.alucontrol, bus.alusrca, bus.alusrcb, bus.regwrite, st[i],
                 alu[i], srb[i]);
      end
      tick();
      vectors++;
      if (bus.state !== 4'd7 || bus.regwrite !== 1'b1 || bus.resultsrc !== 2'b00) begin
        miscompares++;
        $display("FAIL aluwb vec%0d: got state=%0d regwrite=%b resultsrc=%b, want 7 1 00", i,
                 bus.state, bus.regwrite, bus.resultsrc);
      end
      tick();
      vectors++;
      if (bus.state !== 4'd0) begin
        miscompares++;
        $display("FAIL alu_done vec%0d: got state=%0d, want 0", i, bus.state);
      end
    end
  endtask

  task automatic test_beq();
    bus.mem_ready = 1'b1;
    set_instr(7'b1100011, 3'b000, 1'b0);
    for (int z = 1; z >= 0; z--) begin
      bus.zero = z[0];
      do_reset();
      tick();
      tick();
      vectors++;
      if (bus.state !== 4'd10 || bus.pcwrite !== z[0] || bus.alucontrol !== 3'b001 ||
          bus.immsrc !== 2'b10 || bus.regwrite !== 1'b0) begin
        miscompares++;
        $display("FAIL beq zero=%0d: got state=%0d pcwrite=%b alu=%b immsrc=%b rw=%b", z,
                 bus.state, bus.pcwrite, bus.alucontrol, bus.immsrc, bus.regwrite);
      end
      tick();
      vectors++;
      if (bus.state !== 4'd0) begin
        miscompares++;
        $display("FAIL beq_done zero=%0d: got state=%0d, want 0", z, bus.state);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
    bus.mem_ready = 1'b1;
    set_instr(7'b1101111, 3'b000, 1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (bus.state !== exp_st[i] || bus.pcwrite !== (i == 0 || i == 2 || i == 4) ||
          bus.regwrite !== (i == 3) || bus.immsrc !== 2'b11) begin
        miscompares++;
        $display("FAIL jal step%0d: got state=%0d pcwrite=%b regwrite=%b immsrc=%b, want %0d",
                 i, bus.state, bus.pcwrite, bus.regwrite, bus.immsrc, exp_st[i]);
      end
      if (i == 2) begin
        vectors++;
        if (bus.alusrca !== 2'b01 || bus.alusrcb !== 2'b10 || bus.alucontrol !== 3'b000) begin
          miscompares++;
          $display("FAIL jal_mux: got a=%b b=%b alu=%b, want 01 10 000", bus.alusrca,
                   bus.alusrcb, bus.alucontrol);
        end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_illegal();
    bus.mem_ready = 1'b1;
    set_instr(7'b1111111, 3'b000, 1'b0);
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.state !== 4'd11 || bus.illegal !== 1'b1 || strobes !== 5'b0) begin
        miscompares++;
        $display("FAIL trap cyc%0d: got state=%0d illegal=%b strobes=%b, want 11 1 00000", i,
                 bus.state, bus.illegal, strobes);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.illegal !== 1'b0 || strobes !== 5'b0) begin
      miscompares++;
      $display("FAIL trap_reset: got illegal=%b strobes=%b, want 0 00000", bus.illegal, strobes);
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL trap_cleared: got state=%0d illegal=%b, want 0 0", bus.state, bus.illegal);
    end
  endtask

  task automatic test_reset_mid();
    // Reset while stalled in MEMREAD, then while stalled in MEMWRITE.
    logic [6:0] ops [2] = '{7'b0000011, 7'b0100011};
    logic [3:0] st  [2] = '{4'd3, 4'd5};
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = 1'b1;
      set_instr(ops[i], 3'b010, 1'b0);
      do_reset();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      vectors++;
      if (bus.state !== st[i]) begin
        miscompares++;
        $display("FAIL mid_stall op%0d: got state=%0d, want %0d", i, bus.state, st[i]);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (strobes !== 5'b0) begin
        miscompares++;
        $display("FAIL mid_reset_strobes op%0d: got %b, want 00000", i, strobes);
      end
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if (bus.state !== 4'd0 || bus.regwrite !== 1'b0 || bus.memwrite !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_fetch op%0d: got state=%0d rw=%b mw=%b, want 0 0 0", i,
                 bus.state, bus.regwrite, bus.memwrite);
      end
    end
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.op        = 7'b0;
    bus.funct3    = 3'b0;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: every task is a fixed sequence of cycles, so this only fires on a broken clock.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
